// File: rtl/img_pkg.sv
// Purpose : shared image-path constants and the receive-controller state type.
// Latency : n/a (declarations only).
// Backpressure : n/a.
// Contents: DATA_W/ADDR_W bus widths, populated SRAM geometry, rx_state_e.
package img_pkg;

  localparam int DATA_W       = 8;    // pixel / SRAM data width
  localparam int ADDR_W       = 8;    // row / column index width (up to 255x255)
  localparam int IMG_MAX_ROWS = 128;  // rows physically present in img_sram_4_64
  localparam int IMG_MAX_COLS = 128;  // columns physically present in img_sram_4_64

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_RECV = 2'd1,
    RX_DONE = 2'd2
  } rx_state_e;

endpackage

// File: rtl/img_addr_counter.sv
// Purpose : row-major row/col address generator with latched image dimensions.
// Latency : address registers update on the edge where i_clr or i_step is high.
// Backpressure : none; the owner simply withholds i_step to hold the address.
// Ports:
//   clk, rstn           clock and async active-low reset
//   i_clr               force row=col=0 (wins over i_step)
//   i_load              capture i_nrows/i_ncols as the image dimensions
//   i_nrows, i_ncols    dimensions presented at load time (must be non-zero)
//   i_step              advance one pixel: col first, wrap to 0 and bump row
//   o_row, o_col        current registered address
//   o_last              current address is the final pixel (nrows-1, ncols-1)
//   o_next_last         the next i_step lands on the final pixel
module img_addr_counter #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_clr,
  input  logic          i_load,
  input  logic [AW-1:0] i_nrows,
  input  logic [AW-1:0] i_ncols,
  input  logic          i_step,
  output logic [AW-1:0] o_row,
  output logic [AW-1:0] o_col,
  output logic          o_last,
  output logic          o_next_last
);

  localparam logic [AW-1:0] ONE = AW'(1);

  logic [AW-1:0] r_nrows;
  logic [AW-1:0] r_ncols;
  logic [AW-1:0] r_row;
  logic [AW-1:0] r_col;

  logic          w_col_wrap;
  logic [AW-1:0] w_nxt_row;
  logic [AW-1:0] w_nxt_col;

  // Dimensions are non-zero whenever stepping, so the minus-one compares
  // never underflow and stay inside AW bits even for 255x255.
  assign w_col_wrap  = (r_col == r_ncols - ONE);
  assign w_nxt_col   = w_col_wrap ? '0 : r_col + ONE;
  assign w_nxt_row   = w_col_wrap ? r_row + ONE : r_row;

  assign o_last      = w_col_wrap && (r_row == r_nrows - ONE);
  assign o_next_last = (w_nxt_row == r_nrows - ONE) && (w_nxt_col == r_ncols - ONE);

  assign o_row       = r_row;
  assign o_col       = r_col;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_nrows <= '0;
      r_ncols <= '0;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      if (i_load) begin
        r_nrows <= i_nrows;
        r_ncols <= i_ncols;
      end
      if (i_clr) begin
        r_row <= '0;
        r_col <= '0;
      end else if (i_step) begin
        r_row <= w_nxt_row;
        r_col <= w_nxt_col;
      end
    end
  end

endmodule

// File: rtl/io_rx_ctrl.sv
// Purpose : capture a row-major pixel stream after a start pulse and write it to the image SRAM.
// Latency : pixel sampled at edge k+p appears on the SRAM bus after that edge; busy spans N cycles.
// Backpressure : none; one pixel per clock is accepted unconditionally while busy.
// Ports:
//   clk, rstn                 clock and async active-low reset
//   en                        start pulse (ignored unless idle with non-zero dimensions)
//   nrows, ncols              image dimensions, latched at the start edge
//   din                       pixel stream, one pixel per clock
//   busy                      transfer in progress
//   sram_row/col/din          SRAM write address and data (registered)
//   sram_write_en             SRAM write strobe
//   sram_sense_en             SRAM read enable, always 0 here
//   sram_dout                 SRAM read data, not used by this block
module io_rx_ctrl #(
  parameter int DATA_W = img_pkg::DATA_W,
  parameter int ADDR_W = img_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic [ADDR_W-1:0] nrows,
  input  logic [ADDR_W-1:0] ncols,
  input  logic [DATA_W-1:0] din,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_row,
  output logic [ADDR_W-1:0] sram_col,
  output logic [DATA_W-1:0] sram_din,
  output logic              sram_write_en,
  output logic              sram_sense_en,
  input  logic [DATA_W-1:0] sram_dout
);

  import img_pkg::*;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  rx_state_e         r_state;
  logic              r_busy;
  logic              r_we;
  logic [DATA_W-1:0] r_din;

  logic              w_start;
  logic              w_clr;
  logic              w_step;
  logic              w_last;
  logic              w_next_last;
  logic              w_unused;

  // Zero-sized images are rejected here so the counter never sees a zero dimension.
  assign w_start = (r_state == RX_IDLE) && en && (nrows != '0) && (ncols != '0);
  // Address returns to (0,0) both for a new image and when leaving DONE.
  assign w_clr   = w_start || (r_state == RX_DONE);
  assign w_step  = (r_state == RX_RECV);

  img_addr_counter #(
    .AW(ADDR_W)
  ) u_addr (
    .clk         (clk),
    .rstn        (rstn),
    .i_clr       (w_clr),
    .i_load      (w_start),
    .i_nrows     (nrows),
    .i_ncols     (ncols),
    .i_step      (w_step),
    .o_row       (sram_row),
    .o_col       (sram_col),
    .o_last      (w_last),
    .o_next_last (w_next_last)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= RX_IDLE;
      r_busy  <= 1'b0;
      r_we    <= 1'b0;
      r_din   <= '0;
    end else begin
      case (r_state)
        RX_IDLE: begin
          if (w_start) begin
            r_busy  <= 1'b1;
            r_we    <= 1'b1;
            r_din   <= din;
            // A 1x1 image is complete on the start edge itself.
            r_state <= ((nrows == ONE) && (ncols == ONE)) ? RX_DONE : RX_RECV;
          end
        end
        RX_RECV: begin
          r_din <= din;
          // The edge that moves the address onto the final pixel ends reception.
          if (w_next_last) begin
            r_state <= RX_DONE;
          end
        end
        RX_DONE: begin
          // Last write is committed by the SRAM on this edge.
          r_busy  <= 1'b0;
          r_we    <= 1'b0;
          r_din   <= '0;
          r_state <= RX_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_we    <= 1'b0;
          r_din   <= '0;
          r_state <= RX_IDLE;
        end
      endcase
    end
  end

  assign busy          = r_busy;
  assign sram_write_en = r_we;
  assign sram_din      = r_din;
  assign sram_sense_en = 1'b0;

  // Read data and the current-last flag are not needed by the receive path.
  assign w_unused = ^{sram_dout, w_last};

endmodule

// File: tb/tb_io_rx_ctrl.sv
module tb_io_rx_ctrl;
  import img_pkg::*;

  logic       clk   = 1'b0;
  logic       rstn  = 1'b0;
  logic       en    = 1'b0;
  logic [7:0] nrows = 8'd0;
  logic [7:0] ncols = 8'd0;
  logic [7:0] din   = 8'd0;
  logic [7:0] sram_dout = 8'hA5;

  logic       busy;
  logic [7:0] sram_row;
  logic [7:0] sram_col;
  logic [7:0] sram_din;
  logic       sram_write_en;
  logic       sram_sense_en;

  io_rx_ctrl dut (
    .clk           (clk),
    .rstn          (rstn),
    .en            (en),
    .nrows         (nrows),
    .ncols         (ncols),
    .din           (din),
    .busy          (busy),
    .sram_row      (sram_row),
    .sram_col      (sram_col),
    .sram_din      (sram_din),
    .sram_write_en (sram_write_en),
    .sram_sense_en (sram_sense_en),
    .sram_dout     (sram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: a write on the bus is committed at the following edge.
  logic [7:0] mem [0:IMG_MAX_ROWS-1][0:IMG_MAX_COLS-1];
  logic       mem_clr = 1'b0;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int r = 0; r < IMG_MAX_ROWS; r++)
        for (int c = 0; c < IMG_MAX_COLS; c++)
          mem[r][c] <= 8'hEE;
    end else if (sram_write_en && !sram_row[7] && !sram_col[7]) begin
      mem[sram_row[6:0]][sram_col[6:0]] <= sram_din;
    end
  end

  // Reference model: a transfer is a pixel index p counting from the start
  // edge; pixel p is shown at row p/ncols, col p%ncols, and the bus goes
  // quiet one edge after the last pixel. Starts are only honoured outside
  // the window [start edge, start edge + N].
  bit         m_act  = 1'b0;
  int         m_p    = 0;
  int         m_n    = 0;
  int         m_nc   = 1;
  logic       e_busy = 1'b0;
  logic       e_we   = 1'b0;
  int         e_row  = 0;
  int         e_col  = 0;
  logic [7:0] e_din  = 8'd0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_act  <= 1'b0;
      m_p    <= 0;
      e_busy <= 1'b0;
      e_we   <= 1'b0;
      e_row  <= 0;
      e_col  <= 0;
      e_din  <= 8'd0;
    end else if (m_act) begin
      if (m_p + 1 < m_n) begin
        m_p   <= m_p + 1;
        e_row <= (m_p + 1) / m_nc;
        e_col <= (m_p + 1) % m_nc;
        e_din <= din;
      end else begin
        m_act  <= 1'b0;
        e_busy <= 1'b0;
        e_we   <= 1'b0;
        e_row  <= 0;
        e_col  <= 0;
        e_din  <= 8'd0;
      end
    end else if (en && (nrows != 8'd0) && (ncols != 8'd0)) begin
      m_act  <= 1'b1;
      m_p    <= 0;
      m_n    <= int'(nrows) * int'(ncols);
      m_nc   <= int'(ncols);
      e_busy <= 1'b1;
      e_we   <= 1'b1;
      e_row  <= 0;
      e_col  <= 0;
      e_din  <= din;
    end
  end

  int         n_vec   = 0;
  int         n_miss  = 0;
  int         busy_cyc = 0;
  int         we_cyc   = 0;
  logic [7:0] img [0:16383];

  task automatic cmp(input string tag);
    n_vec++;
    if (busy !== e_busy || sram_write_en !== e_we || sram_sense_en !== 1'b0 ||
        int'(sram_row) != e_row || int'(sram_col) != e_col || sram_din !== e_din) begin
      n_miss++;
      $display("FAIL %s t=%0t got busy=%b we=%b se=%b row=%0d col=%0d din=%h want busy=%b we=%b se=0 row=%0d col=%0d din=%h",
               tag, $time, busy, sram_write_en, sram_sense_en, sram_row, sram_col, sram_din,
               e_busy, e_we, e_row, e_col, e_din);
    end
  endtask

  task automatic chk(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_miss++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  // One clock: inputs already set, check outputs at the falling edge.
  task automatic cyc(input string tag);
    @(posedge clk);
    @(negedge clk);
    cmp(tag);
    if (busy) busy_cyc++;
    if (sram_write_en) we_cyc++;
  endtask

  task automatic clear_mem();
    mem_clr = 1'b1;
    cyc("memclr");
    mem_clr = 1'b0;
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) img[i] = 8'($urandom);
  endtask

  // Drive one image; retrig (pixel index) and rnd_en inject ignored en pulses.
  // Dimension inputs are scrambled after the start edge to prove latching.
  task automatic xfer(input int nr, input int nc, input int retrig, input bit rnd_en);
    int n;
    n = nr * nc;
    en = 1'b1; nrows = 8'(nr); ncols = 8'(nc); din = img[0];
    cyc("start");
    for (int p = 1; p <= n; p++) begin
      en    = (p == retrig) || (rnd_en && ($urandom_range(0, 3) == 0));
      nrows = 8'($urandom);
      ncols = 8'($urandom);
      din   = (p < n) ? img[p] : 8'($urandom);
      cyc("recv");
    end
    en = 1'b0;
  endtask

  task automatic mem_match(input string nm, input int nr, input int nc);
    int bad;
    bad = 0;
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < nc; c++)
        if (mem[r][c] !== img[r*nc + c]) bad++;
    chk(nm, bad, 0);
  endtask

  initial begin
    int b0;
    int w0;

    // Reset and idle outputs.
    repeat (3) cyc("reset");
    chk("rst_busy", int'(busy), 0);
    chk("rst_we", int'(sram_write_en), 0);
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      en = 1'b0; nrows = 8'($urandom); ncols = 8'($urandom); din = 8'($urandom);
      cyc("idle");
    end
    chk("idle_sense", int'(sram_sense_en), 0);
    chk("idle_addr", int'({sram_row, sram_col}), 0);

    // Small 2x3 image with known pixels.
    clear_mem();
    for (int p = 0; p < 6; p++) img[p] = 8'(16 + p);
    b0 = busy_cyc; w0 = we_cyc;
    xfer(2, 3, -1, 1'b0);
    chk("small_busy_cycles", busy_cyc - b0, 6);
    chk("small_we_cycles", we_cyc - w0, 6);
    chk("small_m00", int'(mem[0][0]), 'h10);
    chk("small_m02", int'(mem[0][2]), 'h12);
    chk("small_m10", int'(mem[1][0]), 'h13);
    chk("small_m12", int'(mem[1][2]), 'h15);
    chk("small_m03_untouched", int'(mem[0][3]), 'hEE);
    chk("small_m20_untouched", int'(mem[2][0]), 'hEE);

    // Re-trigger at pixel 3 of a 2x3 transfer.
    clear_mem();
    fill_rand(6);
    b0 = busy_cyc;
    xfer(2, 3, 3, 1'b0);
    chk("retrig_busy_cycles", busy_cyc - b0, 6);
    mem_match("retrig_mem", 2, 3);

    // Zero-sized requests.
    b0 = busy_cyc; w0 = we_cyc;
    en = 1'b1; nrows = 8'd0; ncols = 8'd5; din = 8'h55; cyc("zero_a");
    en = 1'b1; nrows = 8'd4; ncols = 8'd0; cyc("zero_b");
    en = 1'b0;
    repeat (3) cyc("zero_idle");
    chk("zero_busy_cycles", busy_cyc - b0, 0);
    chk("zero_we_cycles", we_cyc - w0, 0);

    // Reset after five pixels of a 4x4 transfer have been committed.
    clear_mem();
    fill_rand(16);
    en = 1'b1; nrows = 8'd4; ncols = 8'd4; din = img[0];
    cyc("mid_start");
    for (int p = 1; p <= 5; p++) begin
      en = 1'b0; din = img[p];
      cyc("mid_recv");
    end
    rstn = 1'b0;
    #1;
    chk("midrst_busy_async", int'(busy), 0);
    chk("midrst_we_async", int'(sram_write_en), 0);
    chk("midrst_addr_async", int'({sram_row, sram_col}), 0);
    cyc("mid_reset");
    rstn = 1'b1;
    cyc("mid_release");
    chk("midrst_m03", int'(mem[0][3]), int'(img[3]));
    chk("midrst_m10", int'(mem[1][0]), int'(img[4]));
    chk("midrst_m11_untouched", int'(mem[1][1]), 'hEE);
    chk("midrst_m12_untouched", int'(mem[1][2]), 'hEE);
    fill_rand(4);
    xfer(2, 2, -1, 1'b0);
    mem_match("restart_mem", 2, 2);

    // Dimension boundaries, including near-255 row/column indices.
    fill_rand(510);
    xfer(1, 1, -1, 1'b1);
    xfer(1, 7, -1, 1'b1);
    xfer(7, 1, -1, 1'b1);
    xfer(2, 255, -1, 1'b1);
    xfer(255, 2, -1, 1'b1);

    // Randomised transfers with random gaps and stray en pulses.
    for (int t = 0; t < 30; t++) begin
      int nr;
      int nc;
      nr = $urandom_range(1, 12);
      nc = $urandom_range(1, 12);
      fill_rand(nr * nc);
      xfer(nr, nc, -1, 1'b1);
      repeat ($urandom_range(0, 3)) begin
        nrows = 8'($urandom); ncols = 8'($urandom); din = 8'($urandom);
        cyc("gap");
      end
    end

    // Full 128x128 image.
    clear_mem();
    fill_rand(16384);
    b0 = busy_cyc;
    xfer(128, 128, -1, 1'b0);
    chk("full_busy_cycles", busy_cyc - b0, 16384);
    mem_match("full_mem", 128, 128);

    repeat (10) cyc("tail");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
